// File: rtl/axi_interconnect_pkg.sv
// Shared AXI interconnect definitions: burst type codes and the
// write-address splitter state encoding.
package axi_interconnect_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1
  } aw_state_e;

endpackage

// File: rtl/axi_interconnect_width_convert_awsplit.sv
// Write-address splitter: one slave AW burst -> one or more master AW
// sub-bursts, with one request-FIFO push per issued sub-burst.
//
// Ports:
//   clk_sys, rst         clock, synchronous active-high reset
//   s_aw*                slave AW channel (s_awready out)
//   m_aw*                master AW channel, all outputs registered
//   req_en / req_last    request-FIFO push and final-sub-burst flag
//
// Build option: AXI_IC_AWSPLIT_ALIGN_EN makes INCR sub-bursts after the
// first start on a (MAX_BURST_LEN << size)-byte boundary.
module axi_interconnect_width_convert_awsplit
  import axi_interconnect_pkg::*;
#(
  parameter int WIDTH_ID      = 4,
  parameter int WIDTH_AUSER   = 1,
  parameter int WIDTH_ADDR    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int U_DLY         = 1,
  localparam int W_ID    = (WIDTH_ID == 0) ? 1 : WIDTH_ID,
  localparam int W_AUSER = (WIDTH_AUSER == 0) ? 1 : WIDTH_AUSER
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [W_ID-1:0]       s_awid,
  input  logic [WIDTH_ADDR-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic [W_AUSER-1:0]    s_awuser,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  output logic [W_ID-1:0]       m_awid,
  output logic [WIDTH_ADDR-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic [W_AUSER-1:0]    m_awuser,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic                  req_en,
  output logic                  req_last
);

  localparam logic [8:0] MAXB = 9'(MAX_BURST_LEN);

  aw_state_e r_state;
  // Beats still to issue after the sub-burst currently on m_aw*.
  logic [8:0] r_remain;

  logic [WIDTH_ADDR-1:0] w_addr;
  logic [WIDTH_ADDR-1:0] w_mask;
  logic [WIDTH_ADDR-1:0] w_step;
  logic [8:0]            w_remain;
  logic [8:0]            w_align;
  logic [8:0]            w_cap;
  logic [8:0]            w_beats;
  logic [8:0]            w_remain_after;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_unused_dly;

  // Delay parameter kept for interface compatibility only.
  assign w_unused_dly = (U_DLY != 0);

  assign s_awready = (r_state == ST_IDLE);
  assign req_en    = m_awvalid & m_awready;
  assign req_last  = (r_remain == 9'd0);

  // Sizing of the sub-burst to load next: from the slave request when
  // idle, otherwise the continuation of the one being issued.
  always_comb begin
    w_mask         = '0;
    w_step         = '0;
    w_addr         = '0;
    w_remain       = '0;
    w_size         = '0;
    w_burst        = '0;
    w_align        = 9'd256;
    w_cap          = MAXB;
    w_beats        = '0;
    w_remain_after = '0;
    if (r_state == ST_IDLE) begin
      w_remain = {1'b0, s_awlen} + 9'd1;
      w_addr   = s_awaddr;
      w_size   = s_awsize;
      w_burst  = s_awburst;
    end else begin
      w_remain = r_remain;
      w_mask   = (WIDTH_ADDR'(1) << m_awsize) - WIDTH_ADDR'(1);
      w_step   = WIDTH_ADDR'({1'b0, m_awlen} + 9'd1) << m_awsize;
      // Later sub-bursts restart from the size-aligned address.
      w_addr   = (m_awaddr & ~w_mask) + w_step;
      w_size   = m_awsize;
      w_burst  = m_awburst;
    end
`ifdef AXI_IC_AWSPLIT_ALIGN_EN
    w_align = MAXB - 9'((w_addr >> w_size)
                        & WIDTH_ADDR'(MAX_BURST_LEN - 1));
`else
    w_align = 9'd256;
`endif
    w_cap = (w_align < MAXB) ? w_align : MAXB;
    // Non-INCR and short bursts are never split.
    if ((w_burst != AXI_BURST_INCR) || (w_remain <= MAXB)) begin
      w_beats = w_remain;
    end else begin
      w_beats = (w_remain < w_cap) ? w_remain : w_cap;
    end
    w_remain_after = w_remain - w_beats;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_remain  <= '0;
      m_awid    <= '0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awsize  <= '0;
      m_awburst <= '0;
      m_awuser  <= '0;
      m_awvalid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (s_awvalid) begin
            m_awid    <= s_awid;
            m_awsize  <= s_awsize;
            m_awburst <= s_awburst;
            m_awuser  <= s_awuser;
            m_awaddr  <= w_addr;
            m_awlen   <= 8'(w_beats - 9'd1);
            r_remain  <= w_remain_after;
            m_awvalid <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_awready) begin
            if (r_remain == 9'd0) begin
              m_awvalid <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              m_awaddr <= w_addr;
              m_awlen  <= 8'(w_beats - 9'd1);
              r_remain <= w_remain_after;
            end
          end
        end
        default: begin
          m_awvalid <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_interconnect_width_convert_awsplit.sv
// Bench for the AW splitter: directed scenarios plus random bursts,
// compared against a burst-splitting reference model.
module tb_axi_interconnect_width_convert_awsplit;

  localparam int MAX = 16;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [3:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic [0:0]  s_awuser;
  logic        s_awvalid;
  logic        s_awready;
  logic [3:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic [0:0]  m_awuser;
  logic        m_awvalid;
  logic        m_awready;
  logic        req_en;
  logic        req_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } sub_t;

  sub_t exp_q[$];

  always #5 clk_sys = ~clk_sys;

  axi_interconnect_width_convert_awsplit #(
    .WIDTH_ID(4), .WIDTH_AUSER(1), .WIDTH_ADDR(32),
    .MAX_BURST_LEN(MAX), .U_DLY(1)
  ) dut (
    .clk_sys(clk_sys), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awuser(s_awuser), .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awuser(m_awuser), .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .req_en(req_en), .req_last(req_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: split a burst into sub-bursts by plain arithmetic.
  task automatic build(input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int     rem;
    int     b;
    int     unit;
    longint a;
    sub_t   s;
    rem  = int'(len) + 1;
    a    = longint'(addr);
    unit = 1 << size;
    exp_q.delete();
    while (rem > 0) begin
      if (burst != 2'b01 || int'(len) + 1 <= MAX) begin
        b = rem;
      end else begin
        b = (rem < MAX) ? rem : MAX;
`ifdef AXI_IC_AWSPLIT_ALIGN_EN
        if (MAX - int'((a / unit) % MAX) < b)
          b = MAX - int'((a / unit) % MAX);
`endif
      end
      s.addr = a[31:0];
      s.len  = 8'(b - 1);
      s.last = (rem == b);
      exp_q.push_back(s);
      rem = rem - b;
      a   = (a / unit) * unit + longint'(b) * unit;
    end
  endtask

  // rmode: 0 ready always, 1 pattern 1,0,0,..., 2 random.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic user,
                           input int rmode);
    int   cyc;
    sub_t f;
    build(addr, len, size, burst);
    @(negedge clk_sys);
    m_awready = 1'b0;
    #1;
    chk("s_awready_idle", 64'(s_awready), 64'd1);
    s_awid    = id;
    s_awaddr  = addr;
    s_awlen   = len;
    s_awsize  = size;
    s_awburst = burst;
    s_awuser  = user;
    s_awvalid = 1'b1;
    @(posedge clk_sys);
    #1;
    s_awvalid = 1'b0;
    chk("latency_valid", 64'(m_awvalid), 64'd1);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      @(negedge clk_sys);
      case (rmode)
        0:       m_awready = 1'b1;
        1:       m_awready = (cyc % 3 == 0);
        default: m_awready = 1'($urandom_range(0, 1));
      endcase
      #1;
      f = exp_q[0];
      chk("m_awvalid", 64'(m_awvalid), 64'd1);
      chk("s_awready_busy", 64'(s_awready), 64'd0);
      chk("m_awaddr", 64'(m_awaddr), 64'(f.addr));
      chk("m_awlen", 64'(m_awlen), 64'(f.len));
      chk("m_awid", 64'(m_awid), 64'(id));
      chk("m_awsize", 64'(m_awsize), 64'(size));
      chk("m_awburst", 64'(m_awburst), 64'(burst));
      chk("m_awuser", 64'(m_awuser), 64'(user));
      chk("req_en", 64'(req_en), 64'(m_awready));
      if (m_awready) begin
        chk("req_last", 64'(req_last), 64'(f.last));
        void'(exp_q.pop_front());
      end
      cyc++;
    end
    if (cyc >= 2000) chk("burst_timeout", 64'd1, 64'd0);
    @(posedge clk_sys);
    #1;
    chk("end_valid_low", 64'(m_awvalid), 64'd0);
    chk("end_s_awready", 64'(s_awready), 64'd1);
    m_awready = 1'b0;
  endtask

  initial begin
    logic [7:0]  len;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [1:0]  burst;
    int          total;
    rst       = 1'b1;
    s_awid    = '0;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    s_awuser  = '0;
    s_awvalid = 1'b0;
    m_awready = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    #1;
    chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_m_awaddr", 64'(m_awaddr), 64'd0);
    chk("rst_m_awlen", 64'(m_awlen), 64'd0);
    chk("rst_m_awid", 64'(m_awid), 64'd0);
    chk("rst_s_awready", 64'(s_awready), 64'd1);
    chk("rst_req_en", 64'(req_en), 64'd0);

    // T1 single INCR sub-burst
    run_burst(4'h3, 32'h1000, 8'd7, 3'd2, 2'b01, 1'b1, 0);
    // T2 three back-to-back sub-bursts
    run_burst(4'h5, 32'h0, 8'd39, 3'd3, 2'b01, 1'b0, 0);
    // T3 same with stalls
    run_burst(4'h6, 32'h0, 8'd39, 3'd3, 2'b01, 1'b1, 1);
    // T4 WRAP and FIXED pass-through
    run_burst(4'h7, 32'h2040, 8'd15, 3'd2, 2'b10, 1'b0, 0);
    run_burst(4'h8, 32'h3000, 8'd31, 3'd2, 2'b00, 1'b1, 1);
    // T5 unaligned INCR start
    run_burst(4'h9, 32'h28, 8'd19, 3'd2, 2'b01, 1'b0, 0);

    // T6 reset after the first of three sub-bursts
    @(negedge clk_sys);
    s_awid    = 4'ha;
    s_awaddr  = 32'h0;
    s_awlen   = 8'd39;
    s_awsize  = 3'd3;
    s_awburst = 2'b01;
    s_awuser  = 1'b0;
    s_awvalid = 1'b1;
    @(posedge clk_sys);
    #1;
    s_awvalid = 1'b0;
    @(negedge clk_sys);
    m_awready = 1'b1;
    #1;
    chk("t6_first_addr", 64'(m_awaddr), 64'h0);
    chk("t6_first_last", 64'(req_last), 64'd0);
    @(negedge clk_sys);
    m_awready = 1'b0;
    #1;
    chk("t6_second_addr", 64'(m_awaddr), 64'h80);
    rst = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("t6_valid_low", 64'(m_awvalid), 64'd0);
    chk("t6_s_awready", 64'(s_awready), 64'd1);
    chk("t6_addr_clr", 64'(m_awaddr), 64'd0);
    @(negedge clk_sys);
    rst       = 1'b0;
    m_awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      #1;
      chk("t6_no_req_en", 64'(req_en), 64'd0);
      chk("t6_idle_valid", 64'(m_awvalid), 64'd0);
    end
    m_awready = 1'b0;
    run_burst(4'hb, 32'h1000, 8'd7, 3'd2, 2'b01, 1'b1, 0);

    // Random bursts
    for (int n = 0; n < 40; n++) begin
      burst = 2'($urandom_range(0, 2));
      size  = 3'($urandom_range(0, 3));
      if (burst == 2'b01) begin
        len   = 8'($urandom_range(0, 255));
        total = (int'(len) + 1) << size;
        if (total > 4096) begin
          len   = 8'((4096 >> size) - 1);
          total = 4096;
        end
        addr = ($urandom & 32'hFFFF_F000)
             | 32'($urandom_range(0, 4096 - total));
      end else if (burst == 2'b10) begin
        len  = 8'((2 << $urandom_range(0, 3)) - 1);
        addr = $urandom & ~((32'd1 << size) - 32'd1);
      end else begin
        len  = 8'($urandom_range(0, 15));
        addr = $urandom;
      end
      run_burst(4'($urandom), addr, len, size, burst,
                1'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
